// File: rtl/demux_12_stream.sv
// demux_12_stream: 1-to-2 packet stream demultiplexer with one registered
// output stage.
//
// Routing: the destination comes from sel_in on the first beat of a packet.
// It is then locked until the beat carrying last_in. All other beats of the
// packet follow the first beat, whatever sel_in shows on them.
//
// Optional feature: define DEMUX_CNT_EN to add the per-port completed-packet
// counters a_pkt_cnt_out / b_pkt_cnt_out. These are 16 bits wide and wrap.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   data_in, valid_in, last_in   upstream beat
//   sel_in                       destination of a first beat (0 = A, 1 = B)
//   ready_out                    upstream ready (combinational from port ready)
//   a_data_out/a_valid_out/a_last_out, a_ready_in   port A stream
//   b_data_out/b_valid_out/b_last_out, b_ready_in   port B stream
//   a_pkt_cnt_out, b_pkt_cnt_out completed packets per port (DEMUX_CNT_EN)
module demux_12_stream #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              last_in,
    input  logic              sel_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] a_data_out,
    output logic              a_valid_out,
    output logic              a_last_out,
    input  logic              a_ready_in,
    output logic [DATA_W-1:0] b_data_out,
    output logic              b_valid_out,
    output logic              b_last_out,
    input  logic              b_ready_in
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]       a_pkt_cnt_out,
    output logic [15:0]       b_pkt_cnt_out
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOCK_A = 2'd1;
    localparam logic [1:0] LOCK_B = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              out_vld;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_dst;
    logic              pop;
    logic              accept;
    logic              in_dst;

    // Only the port that the held beat targets can drain the register.
    assign pop       = out_vld && (out_dst ? b_ready_in : a_ready_in);
    assign ready_out = !out_vld || pop;
    assign accept    = valid_in && ready_out;

    // In a locked state the destination ignores sel_in.
    always_comb begin
        in_dst = sel_in;
        case (state)
            LOCK_A:  in_dst = 1'b0;
            LOCK_B:  in_dst = 1'b1;
            default: in_dst = sel_in;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (last_in)
                state_nxt = IDLE;
            else if (state == IDLE)
                state_nxt = sel_in ? LOCK_B : LOCK_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A pop and an accept in the same cycle reload the register directly,
    // so no bubble is inserted. A beat with no pop and no accept is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            out_dst  <= 1'b0;
        end else if (accept) begin
            out_vld  <= 1'b1;
            out_data <= data_in;
            out_last <= last_in;
            out_dst  <= in_dst;
        end else if (pop) begin
            out_vld  <= 1'b0;
        end
    end

    assign a_data_out  = out_data;
    assign a_last_out  = out_last;
    assign a_valid_out = out_vld && !out_dst;
    assign b_data_out  = out_data;
    assign b_last_out  = out_last;
    assign b_valid_out = out_vld && out_dst;

`ifdef DEMUX_CNT_EN
    // A packet counts as complete when its last beat leaves the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_pkt_cnt_out <= '0;
            b_pkt_cnt_out <= '0;
        end else if (pop && out_last) begin
            if (out_dst)
                b_pkt_cnt_out <= b_pkt_cnt_out + 16'd1;
            else
                a_pkt_cnt_out <= a_pkt_cnt_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_12_stream.sv
// Directed, table-driven bench for demux_12_stream. Each table record holds
// one cycle of inputs. It also holds the ready_out expected before the edge
// and the port outputs expected after it.
module tb_demux_12_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0, last_in = 1'b0, sel_in = 1'b0;
    logic       ready_out;
    logic [7:0] a_data_out, b_data_out;
    logic       a_valid_out, a_last_out, b_valid_out, b_last_out;
    logic       a_ready_in = 1'b1, b_ready_in = 1'b1;
`ifdef DEMUX_CNT_EN
    logic [15:0] a_pkt_cnt_out, b_pkt_cnt_out;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    demux_12_stream #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .valid_in(valid_in), .last_in(last_in), .sel_in(sel_in),
        .ready_out(ready_out),
        .a_data_out(a_data_out), .a_valid_out(a_valid_out), .a_last_out(a_last_out),
        .a_ready_in(a_ready_in),
        .b_data_out(b_data_out), .b_valid_out(b_valid_out), .b_last_out(b_last_out),
        .b_ready_in(b_ready_in)
`ifdef DEMUX_CNT_EN
        , .a_pkt_cnt_out(a_pkt_cnt_out), .b_pkt_cnt_out(b_pkt_cnt_out)
`endif
    );

    typedef struct {
        logic [7:0] d;
        logic       v, l, s, ar, br;
        logic       e_rdy, e_av, e_bv;
        logic [7:0] e_d;
        logic       e_l;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle on the falling edge, check ready_out before the rising
    // edge, then check the registered outputs just after it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        data_in = v.d; valid_in = v.v; last_in = v.l; sel_in = v.s;
        a_ready_in = v.ar; b_ready_in = v.br;
        #1 check({tag, " ready_out"}, ready_out, v.e_rdy);
        @(posedge clk);
        #1;
        check({tag, " a_valid"}, a_valid_out, v.e_av);
        check({tag, " b_valid"}, b_valid_out, v.e_bv);
        if (v.e_av || v.e_bv) begin
            check({tag, " data"}, v.e_av ? a_data_out : b_data_out, v.e_d);
            check({tag, " last"}, v.e_av ? a_last_out : b_last_out, v.e_l);
        end
    endtask

    initial begin
        //            d      v  l  s  ar br  rdy av bv  e_d    e_l
        // single-beat packets
        vecs[0]  = '{8'h11, 1, 1, 0, 1, 1,  1, 1, 0, 8'h11, 1};
        vecs[1]  = '{8'h22, 1, 1, 1, 1, 1,  1, 0, 1, 8'h22, 1};
        vecs[2]  = '{8'h00, 0, 0, 0, 1, 1,  1, 0, 0, 8'h00, 0};
        // mid-packet sel toggling: everything follows the first beat to B
        vecs[3]  = '{8'hA0, 1, 0, 1, 1, 1,  1, 0, 1, 8'hA0, 0};
        vecs[4]  = '{8'hA1, 1, 0, 0, 1, 1,  1, 0, 1, 8'hA1, 0};
        vecs[5]  = '{8'hA2, 1, 0, 1, 1, 1,  1, 0, 1, 8'hA2, 0};
        vecs[6]  = '{8'hA3, 1, 1, 0, 1, 1,  1, 0, 1, 8'hA3, 1};
        vecs[7]  = '{8'h00, 0, 0, 0, 1, 1,  1, 0, 0, 8'h00, 0};
        // backpressure on B for 3 cycles; A ready high must not help
        vecs[8]  = '{8'h5C, 1, 1, 1, 1, 0,  1, 0, 1, 8'h5C, 1};
        vecs[9]  = '{8'h99, 1, 1, 0, 1, 0,  0, 0, 1, 8'h5C, 1};
        vecs[10] = '{8'h00, 0, 0, 0, 1, 0,  0, 0, 1, 8'h5C, 1};
        vecs[11] = '{8'h00, 0, 0, 0, 1, 0,  0, 0, 1, 8'h5C, 1};
        vecs[12] = '{8'h00, 0, 0, 0, 0, 1,  1, 0, 0, 8'h00, 0};
        // back-to-back A A B B with no bubble
        vecs[13] = '{8'h31, 1, 0, 0, 1, 1,  1, 1, 0, 8'h31, 0};
        vecs[14] = '{8'h32, 1, 1, 1, 1, 1,  1, 1, 0, 8'h32, 1};
        vecs[15] = '{8'h41, 1, 0, 1, 1, 1,  1, 0, 1, 8'h41, 0};
        vecs[16] = '{8'h42, 1, 1, 0, 1, 1,  1, 0, 1, 8'h42, 1};
        vecs[17] = '{8'h00, 0, 0, 0, 1, 1,  1, 0, 0, 8'h00, 0};

        // reset state
        #3;
        check("rst ready_out", ready_out, 1'b1);
        check("rst a_valid", a_valid_out, 1'b0);
        check("rst b_valid", b_valid_out, 1'b0);
        check("rst a_data", a_data_out, 8'h00);
        check("rst b_last", b_last_out, 1'b0);
`ifdef DEMUX_CNT_EN
        check("rst a_cnt", a_pkt_cnt_out, 16'h0);
        check("rst b_cnt", b_pkt_cnt_out, 16'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++)
            apply(vecs[i], $sformatf("vec%0d", i));

`ifdef DEMUX_CNT_EN
        check("cnt a after table", a_pkt_cnt_out, 16'd2);
        check("cnt b after table", b_pkt_cnt_out, 16'd4);
`endif

        // reset in the middle of a 4-beat A packet
        apply('{8'h61, 1, 0, 0, 1, 1, 1, 1, 0, 8'h61, 0}, "mid1");
        apply('{8'h62, 1, 0, 1, 1, 1, 1, 1, 0, 8'h62, 0}, "mid2");
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst a_valid", a_valid_out, 1'b0);
        check("midrst a_data", a_data_out, 8'h00);
        check("midrst a_last", a_last_out, 1'b0);
        check("midrst ready_out", ready_out, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        // without the reset this would still be locked to A
        apply('{8'h77, 1, 1, 1, 1, 1, 1, 0, 1, 8'h77, 1}, "after_rst");
        apply('{8'h00, 0, 0, 0, 1, 1, 1, 0, 0, 8'h00, 0}, "after_rst_idle");

`ifdef DEMUX_CNT_EN
        check("cnt a after rst", a_pkt_cnt_out, 16'd0);
        check("cnt b after rst", b_pkt_cnt_out, 16'd1);
        // 0xFFFF single-beat packets to A at full rate, then one more.
        @(negedge clk);
        valid_in = 1'b1; last_in = 1'b1; sel_in = 1'b0; a_ready_in = 1'b1; b_ready_in = 1'b1;
        for (int i = 0; i < 16'hFFFF; i++) begin
            data_in = i[7:0];
            @(negedge clk);
        end
        valid_in = 1'b0;
        @(negedge clk);
        check("cnt a at ffff", a_pkt_cnt_out, 16'hFFFF);
        check("cnt b before wrap", b_pkt_cnt_out, 16'd1);
        apply('{8'hEE, 1, 1, 0, 1, 1, 1, 1, 0, 8'hEE, 1}, "wrap");
        apply('{8'h00, 0, 0, 0, 1, 1, 1, 0, 0, 8'h00, 0}, "wrap_idle");
        check("cnt a wrapped", a_pkt_cnt_out, 16'h0000);
        check("cnt b unchanged", b_pkt_cnt_out, 16'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/demux_12_stream.md
# demux_12_stream

- 1-to-2 packet stream demultiplexer with valid/ready handshakes on every port.
- Routes each packet from one upstream stream to output A or output B.
- The destination is selected by `sel_in` on the first beat of the packet and locked until the last beat.
- Sits after a stream source wherever one producer feeds two consumers; it is the inverse of the team's 2:1 selection logic, with one registered output stage for timing closure.

## Interface

- `DATA_W`, default 8, payload width in bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `data_in` input DATA_W: upstream payload.
- `valid_in` input 1: upstream beat valid.
- `last_in` input 1: marks the final beat of a packet.
- `sel_in` input 1: destination (0 = A, 1 = B); sampled only on the first beat of a packet.
- `ready_out` output 1: upstream ready.
- `a_data_out` output DATA_W, `a_valid_out` output 1, `a_last_out` output 1, `a_ready_in` input 1: port A stream.
- `b_data_out` output DATA_W, `b_valid_out` output 1, `b_last_out` output 1, `b_ready_in` input 1: port B stream.
- `a_pkt_cnt_out`, `b_pkt_cnt_out` output 16: completed-packet counters; present only with `DEMUX_CNT_EN`.

## Operation

- **Route FSM:** states IDLE, LOCK_A, LOCK_B. Reset state is IDLE.
- **Acceptance:** a beat is accepted when `valid_in && ready_out`.
- **IDLE:**
  - The destination of an accepted beat is `sel_in`.
  - If `last_in`=1 (single-beat packet), stay in IDLE.
  - Otherwise go to LOCK_A if `sel_in`=0, or LOCK_B if `sel_in`=1.
- **LOCK_x:**
  - Every accepted beat goes to x; `sel_in` is ignored.
  - An accepted beat with `last_in`=1 returns the FSM to IDLE.
- **Output register:** one entry holding `out_vld`, `out_data`, `out_last`, `out_dst`.
  - `a_valid_out` = `out_vld && !out_dst`.
  - `b_valid_out` = `out_vld && out_dst`.
  - Data and last are driven to both ports. The non-selected port's valid is 0.
- **Pop:** occurs when `out_vld` is set and the selected port's ready is 1.
- **Upstream ready:** `ready_out` = `!out_vld || pop`.
  - This is a combinational path from the downstream ready to `ready_out`, which allows full throughput.
- **Simultaneous pop and accept:** the register reloads with the new beat in the same edge. No bubble is inserted.
- **Backpressure:** the register holds `data`, `last` and `dst` stable while valid is high and ready is low. Valid never drops before the handshake completes.
- **Non-selected port:** its ready has no effect.
- **Reset values:**
  - All `*_valid_out`, `*_last_out`, `*_data_out` are 0.
  - `ready_out` is 1.
  - FSM is in IDLE; counters are 0.
- **Reset mid-packet:** the in-flight beat and the packet lock are discarded. The next accepted beat is treated as a first beat.

## Timing

- **Latency:** exactly one cycle. A beat accepted at edge N is visible on its port after edge N, i.e. during cycle N+1.
- **Throughput:** one beat per cycle while the selected consumer holds ready=1.
- **Destination switch:** a packet to B may follow a packet to A back-to-back with no idle cycle, provided the A tail pops in the same cycle.
- **Reset behaviour:** `rst` asserts asynchronously. It deasserts synchronously to `clk` under the system reset synchroniser; this block does no synchronisation.

## Configuration

- **Macro:** `DEMUX_CNT_EN`.
- **When defined:**
  - Adds `a_pkt_cnt_out` and `b_pkt_cnt_out`.
  - Each counter increments by 1 on every pop of a beat with last=1 to its port.
  - Counters are 16-bit, wrap from 0xFFFF to 0x0000, and are reset to 0.
- **When undefined:** the ports and counter logic are absent. All other behaviour is identical.

## Test plan

- **Single-beat packets:** after reset, send beats 0x11 (sel=0, last=1) and 0x22 (sel=1, last=1), both ready high.
  - A sees 0x11 one cycle after acceptance; B sees 0x22 on the next cycle.
  - `ready_out` stays 1 throughout.
- **Mid-packet sel change:** 4-beat packet 0xA0..0xA3, with sel=1 on the first beat and sel toggling on later beats.
  - All four beats appear on B with last only on 0xA3.
  - `a_valid_out` stays 0.
- **Backpressure:** hold `b_ready_in`=0 for 3 cycles while a B-destined beat 0x5C is pending.
  - `b_data_out` stays 0x5C and `b_valid_out` stays 1.
  - `ready_out` is 0 during the stall and returns to 1 in the cycle `b_ready_in` rises.
- **Back-to-back switch:** packet A (2 beats), then packet B (2 beats), streamed every cycle.
  - Four consecutive output beats with no bubble; destinations A, A, B, B.
- **Reset mid-packet:** assert `rst` after beat 2 of a 4-beat A packet.
  - Outputs clear immediately.
  - The next beat, with sel=1 and last=1, routes to B.
- **Counter wrap (`DEMUX_CNT_EN`):** force 0xFFFF packets to A (preload via a long run or a bench shortcut), then send 1 more.
  - `a_pkt_cnt_out` = 0x0000 and `b_pkt_cnt_out` is unchanged.
